// File: rtl/rvm_axi_master_pkg.sv
// Encodings shared by the AXI4-Lite memory initiator: FSM states, response and size codes.
package rvm_axi_master_pkg;

  localparam int unsigned state_w = 3;
  localparam int unsigned size_w  = 3;
  localparam int unsigned resp_w  = 2;

  typedef enum logic [state_w-1:0] {
    st_idle = 3'd0,
    st_ar   = 3'd1,
    st_r    = 3'd2,
    st_aww  = 3'd3,
    st_b    = 3'd4,
    st_resp = 3'd5
  } state_t;

  localparam logic [resp_w-1:0] resp_okay = 2'b00;

  localparam logic [size_w-1:0] size_byte = 3'd0;
  localparam logic [size_w-1:0] size_half = 3'd1;
  localparam logic [size_w-1:0] size_word = 3'd2;

  // A request is rejected when its size is unknown or its address is not size-aligned.
  function automatic logic req_illegal(input logic [size_w-1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      size_byte: bad = 1'b0;
      size_half: bad = addr_lo[0];
      size_word: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rvm_axi_master.sv
// AXI4-Lite initiator: converts the core's single-outstanding request port into
// one AXI4-Lite read or write transaction at a time, ending each in one mem_ack pulse.
module rvm_axi_master
  import rvm_axi_master_pkg::*;
#(
  parameter int unsigned addr_w = 32,
  parameter int unsigned data_w = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  mem_req,
  input  logic                  mem_wen,
  input  logic [addr_w-1:0]     mem_addr,
  input  logic [size_w-1:0]     mem_size,
  input  logic [data_w-1:0]     mem_wdata,
  input  logic [data_w/8-1:0]   mem_strb,
  output logic                  mem_ack,
  output logic [data_w-1:0]     mem_rdata,
  output logic                  mem_error,
  output logic [addr_w-1:0]     M_AXI_ARADDR,
  output logic [size_w-1:0]     M_AXI_ARSIZE,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [data_w-1:0]     M_AXI_RDATA,
  input  logic [resp_w-1:0]     M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [addr_w-1:0]     M_AXI_AWADDR,
  output logic [size_w-1:0]     M_AXI_AWSIZE,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [data_w-1:0]     M_AXI_WDATA,
  output logic [data_w/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [resp_w-1:0]     M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  state_t                state;
  logic [addr_w-1:0]     addr_q;
  logic [size_w-1:0]     size_q;
  logic [data_w-1:0]     wdata_q;
  logic [data_w/8-1:0]   strb_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_hs;
  logic                  w_hs;

  // Payload registers feed both address channels; they only change in IDLE.
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARSIZE = size_q;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_AWSIZE = size_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = strb_q;

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= st_idle;
      addr_q        <= '0;
      size_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      mem_ack       <= 1'b0;
      mem_error     <= 1'b0;
      mem_rdata     <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
    end else begin
      mem_ack <= 1'b0;
      case (state)
        st_idle: begin
          if (mem_req) begin
            addr_q  <= mem_addr;
            size_q  <= mem_size;
            wdata_q <= mem_wdata;
            strb_q  <= mem_strb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (req_illegal(mem_size, mem_addr[1:0])) begin
              mem_ack   <= 1'b1;
              mem_error <= 1'b1;
              state     <= st_resp;
            end else if (mem_wen) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= st_aww;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= st_ar;
            end
          end
        end
        st_ar: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= st_r;
          end
        end
        st_r: begin
          if (M_AXI_RVALID) begin
            mem_rdata    <= M_AXI_RDATA;
            mem_error    <= (M_AXI_RRESP != resp_okay);
            mem_ack      <= 1'b1;
            M_AXI_RREADY <= 1'b0;
            state        <= st_resp;
          end
        end
        st_aww: begin
          // AW and W retire independently; B opens once both are done.
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= st_b;
          end
        end
        st_b: begin
          if (M_AXI_BVALID) begin
            mem_error    <= (M_AXI_BRESP != resp_okay);
            mem_ack      <= 1'b1;
            M_AXI_BREADY <= 1'b0;
            state        <= st_resp;
          end
        end
        st_resp: begin
          mem_error <= 1'b0;
          state     <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_rvm_axi_master.sv
// Randomized bench for rvm_axi_master: a delay-configurable AXI4-Lite responder with a
// word memory, plus a transaction-level model predicting data, error and ack latency.
`timescale 1ns/1ps
module tb_rvm_axi_master;

  logic        ACLK;
  logic        ARESET;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic [31:0] ARADDR;
  logic [2:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  rvm_axi_master #(.addr_w(32), .data_w(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Responder configuration and storage.
  int          ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic [31:0] mem [64];
  logic [31:0] model_mem [64];
  logic [31:0] last_rdata = '0;

  logic [31:0] ar_q[$];
  logic [2:0]  arsize_q[$];
  logic [31:0] r_pend[$];
  logic [31:0] aw_q[$];
  logic [2:0]  awsize_q[$];
  logic [31:0] w_q[$];
  logic [3:0]  wstrb_q[$];
  logic [31:0] aw_mem_q[$];
  logic [31:0] w_mem_q[$];
  logic [3:0]  s_mem_q[$];
  int          valid_seen = 0;

  // AR channel: READY after ar_d cycles of VALID; the handshake lands on the next edge.
  initial begin
    int cnt;
    ARREADY = 1'b0; cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET || !ARVALID) begin ARREADY = 1'b0; cnt = 0; end
      else if (cnt >= ar_d) begin
        ARREADY = 1'b1;
        ar_q.push_back(ARADDR); arsize_q.push_back(ARSIZE); r_pend.push_back(ARADDR);
      end else begin ARREADY = 1'b0; cnt++; end
    end
  end

  initial begin
    int cnt;
    logic [31:0] a;
    RVALID = 1'b0; RDATA = '0; RRESP = '0; cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin RVALID = 1'b0; r_pend.delete(); cnt = 0; end
      else if (RVALID) begin RVALID = 1'b0; RDATA = $urandom; RRESP = 2'($urandom); cnt = 0; end
      else if (RREADY && r_pend.size() > 0) begin
        if (cnt >= r_d) begin
          a = r_pend.pop_front();
          RVALID = 1'b1; RDATA = mem[a[7:2]]; RRESP = rresp_cfg;
        end else cnt++;
      end
    end
  end

  initial begin
    int cnt;
    AWREADY = 1'b0; cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET || !AWVALID) begin AWREADY = 1'b0; cnt = 0; end
      else if (cnt >= aw_d) begin
        AWREADY = 1'b1;
        aw_q.push_back(AWADDR); awsize_q.push_back(AWSIZE); aw_mem_q.push_back(AWADDR);
      end else begin AWREADY = 1'b0; cnt++; end
    end
  end

  initial begin
    int cnt;
    WREADY = 1'b0; cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET || !WVALID) begin WREADY = 1'b0; cnt = 0; end
      else if (cnt >= w_d) begin
        WREADY = 1'b1;
        w_q.push_back(WDATA); wstrb_q.push_back(WSTRB);
        w_mem_q.push_back(WDATA); s_mem_q.push_back(WSTRB);
      end else begin WREADY = 1'b0; cnt++; end
    end
  end

  // B channel commits the write into memory when it responds.
  initial begin
    int cnt;
    logic [31:0] a, d;
    logic [3:0]  s;
    BVALID = 1'b0; BRESP = '0; cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        BVALID = 1'b0; cnt = 0;
        aw_mem_q.delete(); w_mem_q.delete(); s_mem_q.delete();
      end else if (BVALID) begin BVALID = 1'b0; BRESP = 2'($urandom); cnt = 0; end
      else if (BREADY) begin
        if (cnt >= b_d) begin
          BVALID = 1'b1; BRESP = bresp_cfg;
          if (aw_mem_q.size() > 0 && w_mem_q.size() > 0) begin
            a = aw_mem_q.pop_front(); d = w_mem_q.pop_front(); s = s_mem_q.pop_front();
            mem[a[7:2]] = merge(mem[a[7:2]], d, s);
          end
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Protocol monitor: a VALID waiting on READY must hold with a stable payload.
  initial begin
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [2:0]  p_arsize, p_awsize;
    logic [3:0]  p_wstrb;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_arsize = '0; p_awsize = '0; p_wstrb = '0;
    forever begin
      @(negedge ACLK); #1;
      if (!ARESET) begin
        if (p_arv && !p_arr) begin
          check("ar_valid_hold", 32'(ARVALID), 32'd1);
          check("ar_addr_stable", ARADDR, p_araddr);
          check("ar_size_stable", 32'(ARSIZE), 32'(p_arsize));
        end
        if (p_awv && !p_awr) begin
          check("aw_valid_hold", 32'(AWVALID), 32'd1);
          check("aw_addr_stable", AWADDR, p_awaddr);
          check("aw_size_stable", 32'(AWSIZE), 32'(p_awsize));
        end
        if (p_wv && !p_wr) begin
          check("w_valid_hold", 32'(WVALID), 32'd1);
          check("w_data_stable", WDATA, p_wdata);
          check("w_strb_stable", 32'(WSTRB), 32'(p_wstrb));
        end
        if (ARVALID || AWVALID || WVALID) valid_seen++;
      end
      p_arv = ARVALID && !ARESET; p_arr = ARREADY; p_araddr = ARADDR; p_arsize = ARSIZE;
      p_awv = AWVALID && !ARESET; p_awr = AWREADY; p_awaddr = AWADDR; p_awsize = AWSIZE;
      p_wv  = WVALID && !ARESET;  p_wr  = WREADY;  p_wdata  = WDATA;  p_wstrb  = WSTRB;
    end
  end

  task automatic clear_logs();
    ar_q.delete(); arsize_q.delete(); aw_q.delete(); awsize_q.delete(); w_q.delete(); wstrb_q.delete();
  endtask

  // One request end to end; expectations come from the transaction-level rules only.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [3:0] strb);
    bit          illegal, got;
    int          exp_lat, lat, vs0;
    logic        exp_err;
    logic [5:0]  idx;
    idx     = addr[7:2];
    illegal = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    if (illegal) begin
      exp_err = 1'b1; exp_lat = 1;
    end else if (wen) begin
      exp_err = (bresp_cfg != 2'b00);
      exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
      model_mem[idx] = merge(model_mem[idx], wdata, strb);
    end else begin
      exp_err = (rresp_cfg != 2'b00);
      exp_lat = 3 + ar_d + r_d;
      last_rdata = model_mem[idx];
    end
    vs0 = valid_seen;
    clear_logs();
    @(negedge ACLK);
    mem_req = 1'b1; mem_wen = wen; mem_addr = addr; mem_size = size; mem_wdata = wdata; mem_strb = strb;
    lat = 0; got = 0;
    while (lat < 80 && !got) begin
      @(negedge ACLK);
      lat++;
      if (mem_ack) got = 1;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("ack_latency", 32'(lat), 32'(exp_lat));
      check("ack_error", 32'(mem_error), 32'(exp_err));
      check("ack_rdata", mem_rdata, last_rdata);
    end
    // Request stays high through RESP and must be ignored there.
    @(negedge ACLK);
    check("ack_one_cycle", 32'(mem_ack), 32'd0);
    mem_req = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      check("no_extra_ack", 32'(mem_ack), 32'd0);
    end
    if (illegal) begin
      check("illegal_no_bus", 32'(valid_seen - vs0), 32'd0);
    end else if (wen) begin
      check("aw_count", 32'(aw_q.size()), 32'd1);
      check("w_count", 32'(w_q.size()), 32'd1);
      check("ar_count_wr", 32'(ar_q.size()), 32'd0);
      if (aw_q.size() == 1 && w_q.size() == 1) begin
        check("awaddr", aw_q[0], addr);
        check("awsize", 32'(awsize_q[0]), 32'(size));
        check("wdata", w_q[0], wdata);
        check("wstrb", 32'(wstrb_q[0]), 32'(strb));
      end
    end else begin
      check("ar_count", 32'(ar_q.size()), 32'd1);
      check("aw_count_rd", 32'(aw_q.size()), 32'd0);
      if (ar_q.size() == 1) begin
        check("araddr", ar_q[0], addr);
        check("arsize", 32'(arsize_q[0]), 32'(size));
      end
    end
  endtask

  task automatic set_delays(input int a, input int r, input int aw, input int w, input int b);
    ar_d = a; r_d = r; aw_d = aw; w_d = w; b_d = b;
  endtask

  initial begin
    int          k;
    bit          saw, acked;
    logic [31:0] a;
    logic [2:0]  sz;
    ARESET = 1'b1; mem_req = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_size = '0;
    mem_wdata = '0; mem_strb = '0;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; model_mem[i] = mem[i]; end
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_arvalid", 32'(ARVALID), 32'd0);
    check("rst_awvalid", 32'(AWVALID), 32'd0);
    check("rst_wvalid", 32'(WVALID), 32'd0);
    check("rst_rready", 32'(RREADY), 32'd0);
    check("rst_bready", 32'(BREADY), 32'd0);
    check("rst_ack", 32'(mem_ack), 32'd0);
    check("rst_error", 32'(mem_error), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_araddr", ARADDR, 32'd0);

    // Zero-wait word read.
    mem[0] = 32'hDEADBEEF; model_mem[0] = 32'hDEADBEEF;
    set_delays(0, 0, 0, 0, 0);
    run_txn(1'b0, 32'h100, 3'd2, 32'h0, 4'h0);
    check("read_deadbeef", mem_rdata, 32'hDEADBEEF);

    // Write with W accepted two cycles before AW.
    set_delays(0, 0, 2, 0, 0);
    run_txn(1'b1, 32'h204, 3'd2, 32'h12345678, 4'b0011);
    check("write_keeps_rdata", mem_rdata, 32'hDEADBEEF);
    set_delays(0, 0, 0, 0, 0);
    run_txn(1'b0, 32'h204, 3'd2, 32'h0, 4'h0);

    // ARREADY stalled five cycles, then an error read response.
    set_delays(5, 0, 0, 0, 0);
    run_txn(1'b0, 32'h08, 3'd2, 32'h0, 4'h0);
    set_delays(0, 1, 0, 0, 0);
    rresp_cfg = 2'b10;
    run_txn(1'b0, 32'h0C, 3'd2, 32'h0, 4'h0);
    rresp_cfg = 2'b00;

    // Misaligned word read, then simultaneous AW/W with a slow error B.
    run_txn(1'b0, 32'h102, 3'd2, 32'h0, 4'h0);
    set_delays(0, 0, 1, 1, 3);
    bresp_cfg = 2'b11;
    run_txn(1'b1, 32'h40, 3'd2, 32'hCAFEF00D, 4'b1111);
    bresp_cfg = 2'b00;

    // Reset pulsed while waiting in R abandons the read.
    set_delays(0, 30, 0, 0, 0);
    clear_logs();
    @(negedge ACLK);
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h10; mem_size = 3'd2;
    @(negedge ACLK);
    mem_req = 1'b0;
    saw = 0; k = 0;
    while (k < 20 && !saw) begin @(negedge ACLK); k++; if (RREADY) saw = 1; end
    check("reached_r", 32'(saw), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    check("midrst_rready", 32'(RREADY), 32'd0);
    check("midrst_valids", 32'({ARVALID, AWVALID, WVALID, BREADY}), 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    last_rdata = '0;
    @(negedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    acked = 0;
    repeat (25) begin @(negedge ACLK); if (mem_ack) acked = 1; end
    check("no_ack_after_reset", 32'(acked), 32'd0);
    set_delays(0, 0, 0, 0, 0);
    run_txn(1'b0, 32'h10, 3'd2, 32'h0, 4'h0);

    // Randomized mix of sizes, alignments, delays and responses.
    for (int t = 0; t < 40; t++) begin
      k  = $urandom_range(0, 9);
      sz = (k == 9) ? 3'd3 : 3'(k % 3);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      rresp_cfg = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bresp_cfg = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(1'($urandom), a, sz, $urandom, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvm_axi_master.md
# rvm_axi_master

AXI4-Lite initiator that turns the core's single-outstanding memory request port into AXI4-Lite read and write transactions. It drives the `M_AXI_*` channel set into an AXI responder such as the test SRAM. It is the bus-facing end of the RISC-V multi-cycle core's memory path. There is one transaction in flight at a time, and every request ends in exactly one `mem_ack` pulse.

## Interface
Parameters:
- `addr_w`, 32, address width
- `data_w`, 32, data width; only 32 is supported

Ports:
- `ACLK` in 1: master clock
- `ARESET` in 1: asynchronous, active-high reset
- `mem_req` in 1: request strobe, sampled only in IDLE
- `mem_wen` in 1: 1 = write, 0 = read
- `mem_addr` in 32: byte address
- `mem_size` in 3: 0 = byte, 1 = half, 2 = word
- `mem_wdata` in 32: write data, lane-aligned
- `mem_strb` in 4: write byte strobes
- `mem_ack` out 1: one-cycle completion pulse
- `mem_rdata` out 32: read data, valid while `mem_ack`=1
- `mem_error` out 1: error flag, valid while `mem_ack`=1
- `M_AXI_ARADDR` out 32, `M_AXI_ARSIZE` out 3, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1
- `M_AXI_RDATA` in 32, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1
- `M_AXI_AWADDR` out 32, `M_AXI_AWSIZE` out 3, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1
- `M_AXI_WDATA` out 32, `M_AXI_WSTRB` out 4, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1

## Operation
- FSM states: IDLE, AR, R, AWW, B, RESP. All outputs are registered.
- Reset (async, `ARESET`=1):
  - state = IDLE.
  - All VALID/READY outputs, `mem_ack` and `mem_error` go to 0.
  - Address, data, size, strobe and `mem_rdata` registers go to 0.
- IDLE, `mem_req`=1:
  - Latch `mem_addr`, `mem_size`, `mem_wdata`, `mem_strb` and `mem_wen`.
  - Misaligned or illegal request: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size>2. Go to RESP with error=1 and issue no bus traffic.
  - Read: go to AR and assert ARVALID.
  - Write: go to AWW and assert both AWVALID and WVALID.
- AR: hold ARVALID and ARADDR stable until ARREADY. On that handshake edge, drop ARVALID, raise RREADY and go to R.
- R: on RVALID, capture RDATA into `mem_rdata`, set error = (RRESP≠0), drop RREADY and go to RESP.
- AWW:
  - AW and W complete independently; each VALID drops on the edge its READY is seen.
  - When both have completed (including both in the same cycle), raise BREADY and go to B.
- B: on BVALID, set error = (BRESP≠0), drop BREADY and go to RESP.
- RESP: `mem_ack`=1 for exactly one cycle, then go to IDLE. `mem_req` is ignored while in RESP.
- ARSIZE and AWSIZE equal the latched `mem_size`. Addresses are driven unmasked.
- Writes leave `mem_rdata` unchanged.

## Timing
- Min read latency: request accepted at edge 0 → ARVALID high in cycle 1. With zero-wait READY/VALID, `mem_ack` is high in cycle 3.
- Min write latency: `mem_ack` in cycle 3 (AW+W at edge 1, B at edge 2).
- Error/misaligned request: `mem_ack` in cycle 1.
- Back-to-back: the earliest next acceptance is the IDLE cycle after RESP.
- VALID never drops before its handshake, and the payload is stable while VALID=1 (AXI rule).
- No combinational path from any AXI input to any AXI output.
- Reset mid-transaction: the transaction is abandoned. No `mem_ack` is issued, and the responder is reset on the same `ARESET`.

## Structure
- Add to `rvm_constants.v`:
  - FSM state encodings (3-bit).
  - AXI resp codes (OKAY = 2'b00).
  - Size codes (BYTE/HALF/WORD).
- One flat module. No sub-module is warranted; the AW/W completion tracking is two flag registers inside the FSM.

## Test plan
- Read, zero-wait responder: addr 0x100, size 2, RDATA 0xDEADBEEF → ARADDR 0x100, ARSIZE 2; `mem_ack` in cycle 3 with `mem_rdata` 0xDEADBEEF and error 0.
- Write with W accepted 2 cycles before AW: addr 0x204, data 0x12345678, strb 4'b0011 → WVALID drops first, AWVALID holds until its READY; exactly one `mem_ack` with error 0.
- Responder stalls ARREADY for 5 cycles → ARVALID and ARADDR stay stable throughout; `mem_ack` is one cycle long.
- RRESP 2'b10 on a read → `mem_error`=1 while `mem_ack`=1.
- Misaligned word read at 0x102 → no ARVALID ever; `mem_ack` and `mem_error` both in cycle 1.
- `ARESET` pulsed while in R → RREADY and all VALIDs are 0 immediately; no `mem_ack`; the next request is accepted normally.
